// File: rtl/env_player.sv
// env_player: envelope playback sequencer feeding the amplitude/phase modulator.
// Takes pulse commands, reads the envelope RAM word by word, and presents the
// returned words with a gate and the per-pulse amplitude, phase and frequency,
// all aligned to the RAM read latency.
//
// Command handshake: a command transfers on a clk edge where cmd_valid and
// cmd_ready are both 1 and abort is 0. cmd_ready does not depend on cmd_valid.
// It is 1 in IDLE, and in RUN only on the last read cycle so that consecutive
// pulses stream with no bubble. If abort is high in that cycle, the offered
// command is dropped.
module env_player #(
    parameter int NSLICE = 16,
    parameter int AW     = 12,
    parameter int RDLAT  = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [AW-1:0]         cmd_addr,
    input  logic [AW-1:0]         cmd_len,
    input  logic [15:0]           cmd_ampx,
    input  logic [16:0]           cmd_pini,
    input  logic [31:0]           cmd_freq,
    input  logic                  abort,
    output logic                  mem_rden,
    output logic [AW-1:0]         mem_addr,
    input  logic [NSLICE*32-1:0]  mem_rdata,
    output logic [NSLICE*32-1:0]  envxy32x16,
    output logic                  gateout,
    output logic [15:0]           ampx,
    output logic [16:0]           pini,
    output logic [31:0]           freq32,
    output logic                  busy,
    output logic [15:0]           pulse_cnt,
    output logic                  dbg_state
);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t        state;
    logic [AW-1:0] remaining;
    logic [15:0]   cur_ampx;
    logic [16:0]   cur_pini;
    logic [31:0]   cur_freq;
    logic          first_rd;
    logic          last_rd;
    logic          cmd_fire;
    logic          out_last;

    // Tag pipeline: stage i describes the read issued i cycles ago.
    // Stage RDLAT lines up with the matching mem_rdata.
    logic [RDLAT:1] pv;
    logic [RDLAT:1] pf;
    logic [RDLAT:1] pl;
    logic [15:0]    pa [1:RDLAT];
    logic [16:0]    pp [1:RDLAT];
    logic [31:0]    pq [1:RDLAT];

    assign last_rd   = (remaining == AW'(1));
    assign cmd_ready = (state == S_IDLE) || last_rd;
    assign cmd_fire  = cmd_valid && cmd_ready && !abort;
    assign busy      = (state == S_RUN) || (|pv) || gateout;
    assign dbg_state = (state == S_RUN);

    // Sequencer FSM: issues one RAM read per cycle while a pulse is running.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            mem_rden  <= 1'b0;
            mem_addr  <= '0;
            remaining <= '0;
            cur_ampx  <= '0;
            cur_pini  <= '0;
            cur_freq  <= '0;
            first_rd  <= 1'b0;
        end else if (abort) begin
            state    <= S_IDLE;
            mem_rden <= 1'b0;
            first_rd <= 1'b0;
        end else if (cmd_fire && (cmd_len != '0)) begin
            state     <= S_RUN;
            mem_rden  <= 1'b1;
            mem_addr  <= cmd_addr;
            remaining <= cmd_len;
            cur_ampx  <= cmd_ampx;
            cur_pini  <= cmd_pini;
            cur_freq  <= cmd_freq;
            first_rd  <= 1'b1;
        end else if (state == S_RUN) begin
            first_rd <= 1'b0;
            if (last_rd) begin
                state    <= S_IDLE;
                mem_rden <= 1'b0;
            end else begin
                mem_addr  <= mem_addr + AW'(1);
                remaining <= remaining - AW'(1);
            end
        end
    end

    // Delay the read tags and pulse parameters to match the RAM read latency.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pv <= '0;
            pf <= '0;
            pl <= '0;
            for (int i = 1; i <= RDLAT; i++) begin
                pa[i] <= '0;
                pp[i] <= '0;
                pq[i] <= '0;
            end
        end else if (abort) begin
            pv <= '0;
            pf <= '0;
            pl <= '0;
        end else begin
            pv[1] <= mem_rden;
            pf[1] <= first_rd;
            pl[1] <= last_rd;
            pa[1] <= cur_ampx;
            pp[1] <= cur_pini;
            pq[1] <= cur_freq;
            for (int i = 2; i <= RDLAT; i++) begin
                pv[i] <= pv[i-1];
                pf[i] <= pf[i-1];
                pl[i] <= pl[i-1];
                pa[i] <= pa[i-1];
                pp[i] <= pp[i-1];
                pq[i] <= pq[i-1];
            end
        end
    end

    // Output stage: register envelope and gate, switch pulse parameters on a
    // pulse's first word, count a pulse once its last word has been shown.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gateout    <= 1'b0;
            envxy32x16 <= '0;
            ampx       <= '0;
            pini       <= '0;
            freq32     <= '0;
            out_last   <= 1'b0;
            pulse_cnt  <= '0;
        end else if (abort) begin
            gateout    <= 1'b0;
            envxy32x16 <= '0;
            out_last   <= 1'b0;
        end else begin
            gateout    <= pv[RDLAT];
            envxy32x16 <= pv[RDLAT] ? mem_rdata : '0;
            out_last   <= pv[RDLAT] && pl[RDLAT];
            if (pv[RDLAT] && pf[RDLAT]) begin
                ampx   <= pa[RDLAT];
                pini   <= pp[RDLAT];
                freq32 <= pq[RDLAT];
            end
            if (out_last) begin
                pulse_cnt <= pulse_cnt + 16'd1;
            end
        end
    end

endmodule
